// File: rtl/vc_ibuf.sv
// Per-virtual-channel input FIFO with XY route computation on the head flit.
// The computed port/ovch stay locked from the head until the packet's tail is popped.
module vc_ibuf #(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0,
    parameter int VCHID    = 0,
    parameter int ARRAYX   = 4,
    parameter int DEPTH    = 4,
    parameter int FLITW    = 34
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [FLITW-1:0] idata,
    input  logic             ivalid,
    output logic             ordy,
    output logic [FLITW-1:0] bdata,
    output logic             bempty,
    input  logic             send,
    output logic [2:0]       port,
    output logic [1:0]       ovch,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    MY_X     = 4'(ROUTERID % ARRAYX);
    localparam logic [3:0]    MY_Y     = 4'(ROUTERID / ARRAYX);

    typedef enum logic [1:0] {
        FT_BODY     = 2'b00,
        FT_HEAD     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } ftype_t;

    typedef enum logic [2:0] {
        P_XPOS  = 3'd0,
        P_XNEG  = 3'd1,
        P_YPOS  = 3'd2,
        P_YNEG  = 3'd3,
        P_LOCAL = 3'd4
    } port_t;

    logic [FLITW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             lock;

    logic [FLITW-1:0] head;
    ftype_t           head_type;
    logic [3:0]       dst_x;
    logic [3:0]       dst_y;
    logic             full;
    logic             push;
    logic             pop;
    logic             head_opens;
    logic             head_closes;
    logic             route_now;
    port_t            route_port;

    always_comb begin
        full        = (count == FULL_CNT);
        bempty      = (count == '0);
        ordy        = !full;
        pop         = send && !bempty;
        // A full FIFO still takes a flit when the head leaves in the same cycle.
        push        = ivalid && (!full || pop);
        head        = mem[rd_ptr];
        bdata       = bempty ? '0 : head;
        head_type   = ftype_t'(head[FLITW-1 -: 2]);
        dst_x       = head[7:4];
        dst_y       = head[3:0];
        head_opens  = (head_type == FT_HEAD) || (head_type == FT_HEADTAIL);
        head_closes = (head_type == FT_TAIL) || (head_type == FT_HEADTAIL);
        route_now   = !bempty && !lock && head_opens;
    end

    // Dimension-ordered XY routing: resolve X fully before moving in Y.
    always_comb begin
        route_port = P_LOCAL;
        if (dst_x > MY_X)
            route_port = P_XPOS;
        else if (dst_x < MY_X)
            route_port = P_XNEG;
        else if (dst_y > MY_Y)
            route_port = P_YPOS;
        else if (dst_y < MY_Y)
            route_port = P_YNEG;
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide what is
    // valid, and bdata is forced to zero while empty, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= idata;
    end

    // NOTE: all state uses non-blocking assignments so every branch below sees the
    // pre-edge values of count, lock and the pointers.
    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            lock   <= 1'b0;
            port   <= 3'd0;
            ovch   <= 2'd0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (ivalid && !push)
                ovf <= 1'b1;

            if (route_now) begin
                port <= route_port;
                ovch <= 2'(VCHID);
            end

            // Tail departure wins so a HEADTAIL popped unrouted never leaves a stale lock.
            if (pop && head_closes)
                lock <= 1'b0;
            else if (route_now)
                lock <= 1'b1;
        end
    end

    a_params_legal: assert property (@(posedge clk)
        (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (VCHID >= 0) && (VCHID < 4)
        && (PCHID >= 0) && (ARRAYX > 0));

    a_count_bound: assert property (@(posedge clk) disable iff (rst_)
        count <= FULL_CNT);

    a_ovf_sticky: assert property (@(posedge clk) disable iff (rst_)
        ovf |=> ovf);

endmodule

// File: tb/tb_vc_ibuf.sv
// Randomized and directed bench for vc_ibuf, checked every cycle against a
// queue-based packet model at ROUTERID 5 on a 4-wide mesh (router at x=1, y=1).
module tb_vc_ibuf;

    localparam int ROUTERID = 5;
    localparam int ARRAYX   = 4;
    localparam int VCHID    = 2;
    localparam int DEPTH    = 4;
    localparam int FLITW    = 34;
    localparam int MY_X     = ROUTERID % ARRAYX;
    localparam int MY_Y     = ROUTERID / ARRAYX;

    typedef logic [FLITW-1:0] flit_t;

    logic        clk = 1'b0;
    logic        rst_;
    flit_t       idata;
    logic        ivalid;
    logic        ordy;
    flit_t       bdata;
    logic        bempty;
    logic        send;
    logic [2:0]  port;
    logic [1:0]  ovch;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    flit_t       q[$];
    bit          m_lock = 0;
    logic [2:0]  m_port = '0;
    logic [1:0]  m_ovch = '0;
    bit          m_ovf  = 0;

    vc_ibuf #(
        .ROUTERID (ROUTERID),
        .PCHID    (1),
        .VCHID    (VCHID),
        .ARRAYX   (ARRAYX),
        .DEPTH    (DEPTH),
        .FLITW    (FLITW)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .idata  (idata),
        .ivalid (ivalid),
        .ordy   (ordy),
        .bdata  (bdata),
        .bempty (bempty),
        .send   (send),
        .port   (port),
        .ovch   (ovch),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic flit_t mk(input logic [1:0] t, input logic [3:0] dx, input logic [3:0] dy);
        logic [23:0] payload;
        payload = 24'($urandom);
        return {t, payload, dx, dy};
    endfunction

    function automatic logic [2:0] xy_route(input flit_t f);
        int dx = int'(f[7:4]);
        int dy = int'(f[3:0]);
        if (dx > MY_X) return 3'd0;
        if (dx < MY_X) return 3'd1;
        if (dy > MY_Y) return 3'd2;
        if (dy < MY_Y) return 3'd3;
        return 3'd4;
    endfunction

    function automatic bit is_head(input flit_t f);
        return f[FLITW-1 -: 2] == 2'b01 || f[FLITW-1 -: 2] == 2'b11;
    endfunction

    function automatic bit is_tail(input flit_t f);
        return f[FLITW-1 -: 2] == 2'b10 || f[FLITW-1 -: 2] == 2'b11;
    endfunction

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_edge(input logic v, input flit_t d, input logic s, input logic r);
        bit    empty;
        bit    do_pop;
        bit    do_push;
        flit_t hd;
        if (r) begin
            q.delete();
            m_lock = 0;
            m_port = '0;
            m_ovch = '0;
            m_ovf  = 0;
            return;
        end
        empty   = (q.size() == 0);
        hd      = empty ? '0 : q[0];
        do_pop  = s && !empty;
        do_push = v && (q.size() < DEPTH || do_pop);
        if (v && !do_push)
            m_ovf = 1;
        if (!empty && !m_lock && is_head(hd)) begin
            m_port = xy_route(hd);
            m_ovch = 2'(VCHID);
            m_lock = !(do_pop && is_tail(hd));
        end else if (do_pop && is_tail(hd)) begin
            m_lock = 0;
        end
        if (do_pop)
            void'(q.pop_front());
        if (do_push)
            q.push_back(d);
    endtask

    task automatic compare_all();
        check("ordy",   64'(ordy),   64'(q.size() < DEPTH));
        check("bempty", 64'(bempty), 64'(q.size() == 0));
        check("bdata",  64'(bdata),  64'(q.size() == 0 ? flit_t'(0) : q[0]));
        check("port",   64'(port),   64'(m_port));
        check("ovch",   64'(ovch),   64'(m_ovch));
        check("ovf",    64'(ovf),    64'(m_ovf));
    endtask

    task automatic cycle(input logic v, input flit_t d, input logic s);
        ivalid = v;
        idata  = d;
        send   = s;
        @(posedge clk);
        model_edge(v, d, s, rst_);
        #1;
        compare_all();
    endtask

    initial begin
        flit_t f;
        logic  v;
        logic  s;

        rst_   = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        send   = 1'b0;

        // Reset held two cycles with ivalid asserted
        cycle(1'b1, mk(2'b01, 4'd3, 4'd1), 1'b0);
        cycle(1'b1, mk(2'b01, 4'd3, 4'd1), 1'b0);
        check("reset_bempty", 64'(bempty), 64'd1);
        check("reset_ordy",   64'(ordy),   64'd1);
        check("reset_bdata",  64'(bdata),  64'd0);
        rst_ = 1'b0;

        // Head to (3,1): visible next cycle, routed +X one cycle later
        f = mk(2'b01, 4'd3, 4'd1);
        cycle(1'b1, f, 1'b0);
        check("head_on_bdata", 64'(bdata), 64'(f));
        cycle(1'b0, '0, 1'b0);
        check("route_xpos", 64'(port), 64'd0);
        check("route_ovch", 64'(ovch), 64'(VCHID));
        cycle(1'b1, mk(2'b10, 4'd0, 4'd0), 1'b1);
        cycle(1'b0, '0, 1'b1);

        // Headtail to (1,0) -> -Y, then (1,1) -> local
        cycle(1'b1, mk(2'b11, 4'd1, 4'd0), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("route_yneg", 64'(port), 64'd3);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk(2'b11, 4'd1, 4'd1), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("route_local", 64'(port), 64'd4);
        cycle(1'b0, '0, 1'b1);

        // Fill, overflow, then push+pop while full
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, mk(2'b00, 4'($urandom), 4'($urandom)), 1'b0);
        check("full_ordy", 64'(ordy), 64'd0);
        cycle(1'b1, mk(2'b00, 4'd2, 4'd2), 1'b0);
        check("ovf_set", 64'(ovf), 64'd1);
        cycle(1'b1, mk(2'b00, 4'd2, 4'd2), 1'b1);
        check("full_pushpop_ordy", 64'(ordy), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, '0, 1'b1);

        // Streamed packet H,B,B,T followed by headtail to (0,1)
        cycle(1'b1, mk(2'b01, 4'd1, 4'd3), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("stream_route", 64'(port), 64'd2);
        cycle(1'b1, mk(2'b00, 4'd0, 4'd0), 1'b1);
        cycle(1'b1, mk(2'b00, 4'd3, 4'd3), 1'b1);
        check("stream_hold", 64'(port), 64'd2);
        cycle(1'b1, mk(2'b10, 4'd0, 4'd0), 1'b1);
        cycle(1'b1, mk(2'b11, 4'd0, 4'd1), 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("next_pkt_xneg", 64'(port), 64'd1);
        cycle(1'b0, '0, 1'b1);

        // Send while empty is ignored
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("empty_send_bempty", 64'(bempty), 64'd1);

        // Reset with two flits of a routed packet stored
        cycle(1'b1, mk(2'b01, 4'd3, 4'd3), 1'b0);
        cycle(1'b1, mk(2'b00, 4'd0, 4'd0), 1'b0);
        cycle(1'b0, '0, 1'b0);
        rst_ = 1'b1;
        cycle(1'b1, mk(2'b01, 4'd0, 4'd0), 1'b0);
        rst_ = 1'b0;
        check("midreset_bempty", 64'(bempty), 64'd1);
        check("midreset_port",   64'(port),   64'd0);
        check("midreset_ovf",    64'(ovf),    64'd0);
        // Lock was cleared: a fresh head is routed at once
        cycle(1'b1, mk(2'b11, 4'd1, 4'd3), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("midreset_relock", 64'(port), 64'd2);
        cycle(1'b0, '0, 1'b1);

        // Random traffic; the controller never pops an unrouted head
        for (int i = 0; i < 3000; i++) begin
            f = mk(2'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            v = 1'($urandom_range(0, 99) < 55);
            s = 1'($urandom_range(0, 99) < 50);
            if (q.size() != 0 && !m_lock && is_head(q[0]))
                s = 1'b0;
            if (i % 700 == 699)
                rst_ = 1'b1;
            cycle(v, f, s);
            rst_ = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
